// File: rtl/line_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_pkg                                                    |
// | Shared state encoding and constants for the line buffer scheduler  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package line_buffer_pkg;

  // A 3x3 window always needs exactly three stored rows.
  localparam int c_NUM_LB = 3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FILL   = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_FLUSH  = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  // Bit positions inside border_o = {top, bottom, left, right}.
  localparam int c_BRD_TOP   = 3;
  localparam int c_BRD_BOT   = 2;
  localparam int c_BRD_LEFT  = 1;
  localparam int c_BRD_RIGHT = 0;

endpackage
`default_nettype wire

// File: rtl/line_buffer_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_scheduler_if                                           |
// | Control/status bundle between pixel source, scheduler, window stage|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface line_buffer_scheduler_if
  import line_buffer_pkg::*;
#(
  parameter int CW     = 10,
  parameter int RW     = 10,
  parameter int NUM_LB = c_NUM_LB
);

  logic              start_i;
  logic              valid_i;
  logic [NUM_LB-1:0] wr_sel_o;
  logic              rd_en_o;
  logic [1:0]        sel_o;
  logic              window_valid_o;
  logic [CW-1:0]     col_o;
  logic [RW-1:0]     row_o;
  logic [3:0]        border_o;
  logic              busy_o;
  logic              done_o;

  // The pixel source / controller drives the frame inputs.
  modport master (
    output start_i, valid_i,
    input  wr_sel_o, rd_en_o, sel_o, window_valid_o,
    input  col_o, row_o, border_o, busy_o, done_o
  );

  modport slave (
    input  start_i, valid_i,
    output wr_sel_o, rd_en_o, sel_o, window_valid_o,
    output col_o, row_o, border_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mod_counter                                                        |
// | Modulo-N up counter with synchronous clear and wrap pulse          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clear,
  input  wire logic             i_enable,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_wrap
);

  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;

  // Wrap is combinational so the caller can chain the next counter in the same cycle.
  assign o_wrap  = i_enable && (r_count == c_LAST);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_scheduler                                              |
// | Write/read sequencing of three line buffers for a 3x3 window stage |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module line_buffer_scheduler
  import line_buffer_pkg::*;
#(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int CW     = 10,
  parameter int RW     = 10,
  parameter int NUM_LB = c_NUM_LB
) (
  input  wire logic              clk,
  input  wire logic              rst,
  line_buffer_scheduler_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_fill;
  logic              w_stream;
  logic              w_flush;
  logic              w_accept;
  logic              w_clear;
  logic              w_rd_en;
  logic              w_row_en;

  logic [CW-1:0]     w_col;
  logic              w_col_wrap;
  logic [RW-1:0]     w_row;
  logic              w_row_wrap;
  logic [1:0]        w_wr_ptr;
  logic              w_ptr_wrap;

  logic [1:0]        r_sel;
  logic              r_win_valid;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [3:0]        w_border;
  logic [NUM_LB-1:0] w_wr_sel;

  assign w_fill   = (r_state == c_FILL);
  assign w_stream = (r_state == c_STREAM);
  assign w_flush  = (r_state == c_FLUSH);
  assign w_accept = bus.valid_i && (w_fill || w_stream);
  assign w_clear  = (r_state == c_IDLE) && bus.start_i;
  assign w_rd_en  = (w_stream && bus.valid_i) || w_flush;
  assign w_row_en = w_accept && w_col_wrap;

  // The column counter also paces the COLS-cycle flush that drains the last row.
  mod_counter #(
    .WIDTH   (CW),
    .MODULUS (COLS)
  ) u_col_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_accept || w_flush),
    .o_count  (w_col),
    .o_wrap   (w_col_wrap)
  );

  mod_counter #(
    .WIDTH   (RW),
    .MODULUS (ROWS)
  ) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_row_en),
    .o_count  (w_row),
    .o_wrap   (w_row_wrap)
  );

  mod_counter #(
    .WIDTH   (2),
    .MODULUS (3)
  ) u_ptr_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_row_en),
    .o_count  (w_wr_ptr),
    .o_wrap   (w_ptr_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (bus.start_i) w_state_nxt = c_FILL;
      c_FILL:   if (w_row_en)    w_state_nxt = c_STREAM;
      c_STREAM: if (w_row_wrap)  w_state_nxt = c_FLUSH;
      c_FLUSH:  if (w_col_wrap)  w_state_nxt = c_DONE;
      c_DONE:                    w_state_nxt = c_IDLE;
      default:                   w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_sel       <= '0;
      r_win_valid <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_valid <= w_rd_en;
      // sel tracks (old wr_ptr + 1) mod 3, i.e. the buffer the row just finished lands behind.
      if (w_clear) begin
        r_sel <= '0;
      end else if (w_row_en) begin
        r_sel <= w_ptr_wrap ? 2'd0 : w_wr_ptr + 2'd1;
      end
      if (w_rd_en) begin
        r_col <= w_col;
        r_row <= w_flush ? RW'(ROWS - 1) : w_row - RW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LB; i++) begin : g_wr_sel
    assign w_wr_sel[i] = w_accept && (w_wr_ptr == 2'(i));
  end

  always_comb begin
    w_border = '0;
    if (r_win_valid) begin
      w_border[c_BRD_TOP]   = (r_row == '0);
      w_border[c_BRD_BOT]   = (r_row == RW'(ROWS - 1));
      w_border[c_BRD_LEFT]  = (r_col == '0);
      w_border[c_BRD_RIGHT] = (r_col == CW'(COLS - 1));
    end
  end

  assign bus.wr_sel_o       = w_wr_sel;
  assign bus.rd_en_o        = w_rd_en;
  assign bus.sel_o          = r_sel;
  assign bus.window_valid_o = r_win_valid;
  assign bus.col_o          = r_col;
  assign bus.row_o          = r_row;
  assign bus.border_o       = w_border;
  assign bus.busy_o         = (r_state != c_IDLE);
  assign bus.done_o         = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_line_buffer_scheduler                                           |
// | Randomized frames against a pixel-count reference model           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_line_buffer_scheduler;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int CW     = 10;
  localparam int RW     = 10;
  localparam int NUM_LB = 3;
  localparam int NPIX   = COLS * ROWS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_buffer_scheduler_if #(.CW(CW), .RW(RW), .NUM_LB(NUM_LB)) bus ();

  line_buffer_scheduler #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CW     (CW),
    .RW     (RW),
    .NUM_LB (NUM_LB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is just a count of accepted pixels and flush cycles.
  bit m_run;
  int m_pix;
  int m_fk;
  int m_reads;
  bit m_prev_rd;
  int m_prev_r;
  int m_prev_c;
  int m_frames;
  int n_done_dut;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_border(input int r, input int c);
    return ((r == 0) ? 8 : 0) | ((r == ROWS - 1) ? 4 : 0) |
           ((c == 0) ? 2 : 0) | ((c == COLS - 1) ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_run     = 1'b0;
    m_pix     = 0;
    m_fk      = 0;
    m_reads   = 0;
    m_prev_rd = 1'b0;
    m_prev_r  = 0;
    m_prev_c  = 0;
  endtask

  task automatic check_cycle(input bit st, input bit vl);
    bit acc;
    bit fl;
    bit dn;
    bit rd;
    int wr;
    acc = m_run && (m_pix < NPIX) && vl;
    fl  = m_run && (m_pix == NPIX) && (m_fk < COLS);
    dn  = m_run && (m_pix == NPIX) && (m_fk == COLS);
    rd  = (acc && (m_pix >= COLS)) || fl;
    wr  = acc ? (1 << ((m_pix / COLS) % 3)) : 0;

    chk("wr_sel", int'(bus.wr_sel_o), wr);
    chk("rd_en", int'(bus.rd_en_o), int'(rd));
    chk("busy", int'(bus.busy_o), int'(m_run));
    chk("done", int'(bus.done_o), int'(dn));
    chk("win_valid", int'(bus.window_valid_o), int'(m_prev_rd));
    chk("border", int'(bus.border_o), m_prev_rd ? exp_border(m_prev_r, m_prev_c) : 0);
    if (m_prev_rd) begin
      chk("col", int'(bus.col_o), m_prev_c);
      chk("row", int'(bus.row_o), m_prev_r);
    end
    if (rd) chk("sel", int'(bus.sel_o), (m_reads / COLS + 1) % 3);
    if (bus.done_o) n_done_dut++;

    m_prev_rd = rd;
    if (rd) begin
      m_prev_r = m_reads / COLS;
      m_prev_c = m_reads % COLS;
      m_reads++;
    end
    if (acc) m_pix++;
    if (fl)  m_fk++;
    if (dn) begin
      m_run = 1'b0;
      m_frames++;
    end else if (!m_run && st) begin
      m_run   = 1'b1;
      m_pix   = 0;
      m_fk    = 0;
      m_reads = 0;
    end
  endtask

  task automatic step(input bit st, input bit vl);
    @(posedge clk);
    #1;
    bus.start_i = st;
    bus.valid_i = vl;
    @(negedge clk);
    check_cycle(st, vl);
  endtask

  task automatic check_reset_zero();
    chk("rst_wr_sel", int'(bus.wr_sel_o), 0);
    chk("rst_rd_en", int'(bus.rd_en_o), 0);
    chk("rst_sel", int'(bus.sel_o), 0);
    chk("rst_win_valid", int'(bus.window_valid_o), 0);
    chk("rst_col", int'(bus.col_o), 0);
    chk("rst_row", int'(bus.row_o), 0);
    chk("rst_border", int'(bus.border_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
  endtask

  // mode 0: continuous valid, 1: toggling 1,0,..., 2: random valid plus stray starts.
  task automatic run_frame(input int mode, input bit kick_at_done);
    int guard;
    bit v;
    bit s;
    step(1'b1, 1'b0);
    guard = 0;
    while (m_run && guard < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ((guard % 2) == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s = (mode >= 2) && ($urandom_range(0, 7) == 0);
      if (kick_at_done && (m_pix == NPIX) && (m_fk == COLS)) s = 1'b1;
      step(s, v);
      guard++;
    end
    step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic reset_mid_frame();
    step(1'b1, 1'b0);
    while (m_pix < COLS + 2) step(1'b0, 1'b1);
    @(posedge clk);
    #2;
    bus.valid_i = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_zero();
    repeat (2) @(negedge clk);
    check_reset_zero();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    m_frames    = 0;
    n_done_dut  = 0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_reset_zero();
    @(negedge clk);
    rst = 1'b1;

    repeat (4) step(1'b0, 1'b1);
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    reset_mid_frame();
    run_frame(0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      run_frame(2, (k % 3) == 0);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)));
    end
    chk("done_total", n_done_dut, m_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_buffer_scheduler.md
Name: line_buffer_scheduler

Overview:
- Sequences the three line buffers that feed the 3x3 sliding-window stage of the streaming filter pipeline.
- Counts incoming pixels by column and row, rotates write enables across the buffers, and starts reads once one full row is stored.
- After the last input row it flushes the final window row with no input, then pulses done.
- Supplies the window stage with its window-valid flag, centre coordinates, border flags and the row-rotation select.

Parameters:
COLS, 640, pixels per image row (2..1024)
ROWS, 480, rows per frame (2..1024)
CW, 10, column counter width (must satisfy 2^CW >= COLS)
RW, 10, row counter width (must satisfy 2^RW >= ROWS)
NUM_LB, 3, number of line buffers (fixed at 3 for a 3x3 window)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle pulse; begins a frame when idle
valid_i  in  1  input pixel valid for this cycle
wr_sel_o  out  NUM_LB  one-hot write enable per line buffer
rd_en_o  out  1  read/shift enable, common to all line buffers
sel_o  out  2  index of the buffer holding the oldest (top) row
window_valid_o  out  1  window at col_o/row_o is valid this cycle
col_o  out  CW  window centre column
row_o  out  RW  window centre row
border_o  out  4  {top,bottom,left,right} padding flags for the current window
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs, counters, wr_ptr and sel_o are cleared to 0. A reset mid-frame abandons the frame; no done_o is produced.
- States:
  - IDLE: on start_i go to FILL and clear in_col, in_row and wr_ptr.
  - FILL (in_row==0): wr_sel_o = valid_i ? (1<<wr_ptr) : 0. rd_en_o=0.
  - STREAM (in_row>=1): writes as in FILL; rd_en_o = valid_i.
  - FLUSH: wr_sel_o=0 and rd_en_o=1 for exactly COLS cycles; valid_i is ignored.
  - DONE: lasts one cycle, then returns to IDLE.
- Counters:
  - in_col advances on each accepted pixel (valid_i in FILL or STREAM) and wraps at COLS-1.
  - On that wrap: in_row++ and wr_ptr = (wr_ptr+1) mod 3.
  - When in_row goes 0->1, move FILL->STREAM.
  - When the pixel at (ROWS-1, COLS-1) is accepted, move STREAM->FLUSH and reset in_col to 0.
- Rotation select: sel_o = (wr_ptr+1) mod 3, registered. It changes only at row wrap.
- Window output (latency 1 cycle from rd_en_o, matching the line buffer read latency):
  - window_valid_o is rd_en_o delayed by one cycle.
  - col_o is the registered in_col.
  - row_o is the registered value of (in_row-1) in STREAM, or ROWS-1 in FLUSH.
- Border flags, computed on the registered coordinates: top = (row_o==0), bottom = (row_o==ROWS-1), left = (col_o==0), right = (col_o==COLS-1). All four are 0 when window_valid_o=0.
- Done: FLUSH->DONE on the cycle after the last flush read. The DONE cycle carries the final window_valid_o and done_o=1 together.
- Edge cases:
  - start_i while busy is ignored.
  - valid_i in IDLE or DONE is ignored.
  - Gaps in valid_i stall FILL and STREAM but never FLUSH.
  - start_i asserted in the DONE cycle is ignored; a new frame needs start_i while in IDLE.
- Frame totals: ROWS*COLS writes and ROWS*COLS window_valid_o cycles per frame.

Decomposition:
- Shared package line_buffer_pkg holds:
  - state encoding IDLE=0, FILL=1, STREAM=2, FLUSH=3, DONE=4 (3 bits);
  - the NUM_LB=3 constant;
  - the border bit order {top,bottom,left,right}.
- One sub-module, mod_counter (parameters: width and modulus; ports: clear, enable, count, wrap pulse). It is instantiated for in_col, in_row and wr_ptr.

Test Plan (COLS=4, ROWS=3 unless stated):
- Continuous frame: start_i, then valid_i=1 for 12 cycles -> 12 writes in one-hot sequence 001 x4, 010 x4, 100 x4. rd_en_o is first high on input pixel 5. window_valid_o is high for 12 cycles total, the last 4 from FLUSH. done_o pulses once, in the same cycle as the window at (2,3).
- Coordinates and borders: over the same frame, check row_o/col_o run (0,0)..(2,3) in raster order. Check border_o: 1010 at (0,0), 1001 at (0,3), 0110 at (2,0), 0101 at (2,3), 0000 at (1,1). Check sel_o=1,2,0 during output rows 0, 1, 2.
- Bubbles: valid_i toggled 1,0,1,0 -> writes and windows occur only on valid cycles, coordinates are unchanged versus the continuous run, and FLUSH still takes exactly 4 consecutive cycles.
- Ignored inputs: valid_i=1 while in IDLE -> no wr_sel_o. start_i in the middle of STREAM -> counters unaffected and only one done_o.
- Reset mid-frame: drive rst=0 during input row 1 -> all outputs are 0 asynchronously and state=IDLE. A following start_i runs a full clean frame that ends with exactly one done_o.
- Large parameters: COLS=640, ROWS=480 -> exactly 307200 writes, 307200 windows and one done_o. The last window is at (479,639) and wr_ptr is 0 at the end of the frame (480 mod 3 = 0).
